des_key_scheduler: RTL and testbench



---
 rtl/des_key_scheduler_if.sv | 26 ++
 rtl/des_key_scheduler.sv | 162 ++++++++++++++++
 tb/tb_des_key_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_scheduler_if.sv
// Handshake/bus bundle between the encipher controller (master) and the DES key scheduler (slave).
// The des_decrypt signal exists only when DES_DECIPHER_EN is defined.
interface des_key_scheduler_if;
    logic        encipher_process;
    logic [63:0] des_key;
`ifdef DES_DECIPHER_EN
    logic        des_decrypt;
`endif
    logic        rkey_sel;
    logic [47:0] round_key;
    logic        round_key_valid;
    logic [3:0]  round_num;
    logic        key_done;

`ifdef DES_DECIPHER_EN
    modport master (output encipher_process, des_key, des_decrypt,
                    input  rkey_sel, round_key, round_key_valid, round_num, key_done);
    modport slave  (input  encipher_process, des_key, des_decrypt,
                    output rkey_sel, round_key, round_key_valid, round_num, key_done);
`else
    modport master (output encipher_process, des_key,
                    input  rkey_sel, round_key, round_key_valid, round_num, key_done);
    modport slave  (input  encipher_process, des_key,
                    output rkey_sel, round_key, round_key_valid, round_num, key_done);
`endif
endinterface

// File: rtl/des_key_scheduler.sv
// DES subkey generator: PC-1 at start, per-round C/D rotation, PC-2, one subkey per clock.
// Optional DES_DECIPHER_EN adds des_decrypt to issue subkeys in reverse (K16 first) order.
module des_key_scheduler (
    input  logic clk,
    input  logic rst,
    des_key_scheduler_if.slave kif
);
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic {IDLE, RUN} state_t;

    // Table bit n is 1-based from the MSB, so bit n of a W-bit vector is index W-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
        return r;
    endfunction

    function automatic logic two_shift(input logic [3:0] r);
        return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

`ifdef DES_DECIPHER_EN
    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction
`endif

    state_t      state;
    logic        proc_d;
    logic        armed;
    logic [27:0] c_q, d_q;
    logic        rkey_sel_q, valid_q, key_done_q;
    logic [47:0] round_key_q;
    logic [3:0]  round_num_q;
`ifdef DES_DECIPHER_EN
    logic        dec_q;
`endif

    logic [55:0] cd0;
    logic [27:0] c_n, d_n;
    logic [3:0]  r_next;
    logic        start;

    assign cd0    = pc1(kif.des_key);
    assign r_next = round_num_q + 4'd1;
    // armed blocks a spurious start when encipher_process is still high as reset releases.
    assign start  = (state == IDLE) && kif.encipher_process && !proc_d && armed;

    always_comb begin
        c_n = c_q;
        d_n = d_q;
        if (state == IDLE) begin
`ifdef DES_DECIPHER_EN
            // Total rotation over 16 rounds is 28, so C0/D0 already yields K16.
            if (kif.des_decrypt) begin
                c_n = cd0[55:28];
                d_n = cd0[27:0];
            end else begin
                c_n = rotl(cd0[55:28], 1'b0);
                d_n = rotl(cd0[27:0], 1'b0);
            end
`else
            c_n = rotl(cd0[55:28], 1'b0);
            d_n = rotl(cd0[27:0], 1'b0);
`endif
        end else begin
`ifdef DES_DECIPHER_EN
            if (dec_q) begin
                c_n = rotr(c_q, two_shift(4'd15 - round_num_q));
                d_n = rotr(d_q, two_shift(4'd15 - round_num_q));
            end else begin
                c_n = rotl(c_q, two_shift(r_next));
                d_n = rotl(d_q, two_shift(r_next));
            end
`else
            c_n = rotl(c_q, two_shift(r_next));
            d_n = rotl(d_q, two_shift(r_next));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            proc_d      <= 1'b0;
            armed       <= 1'b0;
            c_q         <= '0;
            d_q         <= '0;
            rkey_sel_q  <= 1'b0;
            valid_q     <= 1'b0;
            key_done_q  <= 1'b0;
            round_key_q <= '0;
            round_num_q <= '0;
`ifdef DES_DECIPHER_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            proc_d     <= kif.encipher_process;
            key_done_q <= 1'b0;
            if (!kif.encipher_process) armed <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    c_q         <= c_n;
                    d_q         <= d_n;
                    round_key_q <= pc2(c_n, d_n);
                    round_num_q <= 4'd0;
                    valid_q     <= 1'b1;
                    rkey_sel_q  <= 1'b1;
                    state       <= RUN;
`ifdef DES_DECIPHER_EN
                    dec_q       <= kif.des_decrypt;
`endif
                end
                RUN: if (round_num_q == 4'd15) begin
                    valid_q    <= 1'b0;
                    rkey_sel_q <= 1'b0;
                    key_done_q <= 1'b1;
                    state      <= IDLE;
                end else if (!kif.encipher_process) begin
                    valid_q    <= 1'b0;
                    rkey_sel_q <= 1'b0;
                    state      <= IDLE;
                end else begin
                    round_num_q <= r_next;
                    c_q         <= c_n;
                    d_q         <= d_n;
                    round_key_q <= pc2(c_n, d_n);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.rkey_sel        = rkey_sel_q;
    assign kif.round_key       = round_key_q;
    assign kif.round_key_valid = valid_q;
    assign kif.round_num       = round_num_q;
    assign kif.key_done        = key_done_q;
endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed self-checking bench for des_key_scheduler using the classic 0x133457799BBCDFF1 vectors.
module tb_des_key_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    des_key_scheduler_if kif ();
    des_key_scheduler dut (.clk(clk), .rst(rst), .kif(kif));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap;
        kif.encipher_process = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        kif.encipher_process = 1'b0;
        kif.des_key = KEY;
`ifdef DES_DECIPHER_EN
        kif.des_decrypt = 1'b0;
`endif
        tick();
        tick();
        total++;
        if ({kif.rkey_sel, kif.round_key_valid, kif.key_done, kif.round_num, kif.round_key} !== 55'd0) begin
            bad++;
            $display("FAIL reset_outputs: got sel=%b vld=%b done=%b num=%0d key=%h, want all zero",
                     kif.rkey_sel, kif.round_key_valid, kif.key_done, kif.round_num, kif.round_key);
        end
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_encrypt;
        int hi;
        kif.des_key = KEY;
        kif.encipher_process = 1'b1;
        tick();  // E0
        total++;
        if (kif.round_key !== K1 || kif.round_num !== 4'd0 || kif.round_key_valid !== 1'b1 || kif.rkey_sel !== 1'b1) begin
            bad++;
            $display("FAIL enc_k1: got key=%h num=%0d vld=%b sel=%b, want %h 0 1 1",
                     kif.round_key, kif.round_num, kif.round_key_valid, kif.rkey_sel, K1);
        end
        hi = 1;
        for (int n = 1; n < 16; n++) begin
            tick();
            if (kif.rkey_sel === 1'b1) hi++;
            total++;
            if (kif.round_num !== 4'(n) || kif.round_key_valid !== 1'b1) begin
                bad++;
                $display("FAIL enc_round_num: got %0d vld=%b, want %0d vld=1", kif.round_num, kif.round_key_valid, n);
            end
            if (n == 1) begin
                total++;
                if (kif.round_key !== K2) begin
                    bad++;
                    $display("FAIL enc_k2: got %h, want %h", kif.round_key, K2);
                end
            end
            if (n == 15) begin
                total++;
                if (kif.round_key !== K16) begin
                    bad++;
                    $display("FAIL enc_k16: got %h, want %h", kif.round_key, K16);
                end
            end
        end
        tick();  // E0+16
        total++;
        if (kif.key_done !== 1'b1 || kif.rkey_sel !== 1'b0 || kif.round_key_valid !== 1'b0 || kif.round_key !== K16) begin
            bad++;
            $display("FAIL enc_done: got done=%b sel=%b vld=%b key=%h, want 1 0 0 %h",
                     kif.key_done, kif.rkey_sel, kif.round_key_valid, kif.round_key, K16);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (kif.rkey_sel === 1'b1) hi++;
            total++;
            if (kif.key_done !== 1'b0) begin
                bad++;
                $display("FAIL enc_done_pulse: key_done=%b at +%0d, want 0", kif.key_done, i + 17);
            end
        end
        total++;
        if (hi != 16) begin
            bad++;
            $display("FAIL enc_sel_cycles: rkey_sel high %0d cycles, want 16", hi);
        end
        idle_gap();
    endtask

    task automatic test_zero_key;
        int vld_cnt, zero_bad, restart;
        kif.des_key = 64'h0;
        kif.encipher_process = 1'b1;
        vld_cnt = 0; zero_bad = 0; restart = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (kif.round_key_valid === 1'b1) vld_cnt++;
            if (kif.round_key !== 48'h0) zero_bad++;
        end
        total++;
        if (vld_cnt != 16 || zero_bad != 0) begin
            bad++;
            $display("FAIL zero_key: valid cycles=%0d nonzero keys=%0d, want 16 and 0", vld_cnt, zero_bad);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (kif.rkey_sel === 1'b1 || kif.round_key_valid === 1'b1) restart++;
        end
        total++;
        if (restart != 0) begin
            bad++;
            $display("FAIL zero_hold_no_restart: active cycles=%0d, want 0", restart);
        end
        idle_gap();
    endtask

    task automatic test_reset_mid;
        int restart;
        kif.des_key = KEY;
        kif.encipher_process = 1'b1;
        tick();  // E0
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({kif.rkey_sel, kif.round_key_valid, kif.key_done, kif.round_num, kif.round_key} !== 55'd0) begin
            bad++;
            $display("FAIL mid_reset: got sel=%b vld=%b done=%b num=%0d key=%h, want all zero",
                     kif.rkey_sel, kif.round_key_valid, kif.key_done, kif.round_num, kif.round_key);
        end
        restart = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (kif.rkey_sel === 1'b1) restart++;
        end
        total++;
        if (restart != 0) begin
            bad++;
            $display("FAIL mid_reset_no_restart: rkey_sel high %0d cycles, want 0", restart);
        end
        idle_gap();
        kif.encipher_process = 1'b1;
        tick();
        total++;
        if (kif.rkey_sel !== 1'b1 || kif.round_key !== K1) begin
            bad++;
            $display("FAIL mid_reset_restart: got sel=%b key=%h, want 1 %h", kif.rkey_sel, kif.round_key, K1);
        end
        idle_gap();
        tick();
    endtask

    task automatic test_abort;
        int done_seen;
        kif.des_key = KEY;
        kif.encipher_process = 1'b1;
        tick();  // E0
        for (int i = 0; i < 6; i++) tick();
        kif.encipher_process = 1'b0;
        tick();
        total++;
        if (kif.rkey_sel !== 1'b0 || kif.round_key_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs: got sel=%b vld=%b, want 0 0", kif.rkey_sel, kif.round_key_valid);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (kif.key_done === 1'b1) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL abort_no_done: key_done pulses=%0d, want 0", done_seen);
        end
    endtask

    task automatic test_key_change;
        kif.des_key = KEY;
        kif.encipher_process = 1'b1;
        tick();  // E0
        kif.des_key = 64'hFFFF_0000_AAAA_5555;
        tick();
        total++;
        if (kif.round_key !== K2) begin
            bad++;
            $display("FAIL keychg_k2: got %h, want %h", kif.round_key, K2);
        end
        for (int i = 0; i < 14; i++) tick();
        total++;
        if (kif.round_key !== K16 || kif.round_num !== 4'd15) begin
            bad++;
            $display("FAIL keychg_k16: got %h num=%0d, want %h 15", kif.round_key, kif.round_num, K16);
        end
        idle_gap();
        kif.des_key = KEY;
    endtask

`ifdef DES_DECIPHER_EN
    task automatic test_decrypt;
        kif.des_key = KEY;
        kif.des_decrypt = 1'b1;
        kif.encipher_process = 1'b1;
        tick();  // E0
        kif.des_decrypt = 1'b0;
        total++;
        if (kif.round_key !== K16 || kif.round_num !== 4'd0) begin
            bad++;
            $display("FAIL dec_first: got %h num=%0d, want %h 0", kif.round_key, kif.round_num, K16);
        end
        for (int n = 1; n < 16; n++) tick();
        total++;
        if (kif.round_key !== K1 || kif.round_num !== 4'd15) begin
            bad++;
            $display("FAIL dec_last: got %h num=%0d, want %h 15", kif.round_key, kif.round_num, K1);
        end
        tick();
        total++;
        if (kif.key_done !== 1'b1) begin
            bad++;
            $display("FAIL dec_done: key_done=%b, want 1", kif.key_done);
        end
        idle_gap();
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt();
        test_zero_key();
        test_reset_mid();
        test_abort();
        test_key_change();
`ifdef DES_DECIPHER_EN
        test_decrypt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
